// File: rtl/inv74_pkg.sv
// rtl/inv74_pkg.sv - shared types, gate count and popcount helper for the 74x04 quad inverter
package inv74_pkg;

  localparam int N_GATES = 4;

  typedef logic [3:0] quad_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/inv74_gate.sv
// rtl/inv74_gate.sv - single inverter gate; registered output under INV_74X04_OUTPUT_REG_EN
module inv74_gate (
`ifdef INV_74X04_OUTPUT_REG_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic a,
  output logic y
);

`ifdef INV_74X04_OUTPUT_REG_EN
  // Reset value matches the output of an all-0 input
  always_ff @(posedge clk) begin
    if (rst) begin
      y <= 1'b1;
    end else begin
      y <= ~a;
    end
  end
`else
  assign y = ~a;
`endif

endmodule

// File: rtl/inv_74x04_quad.sv
// rtl/inv_74x04_quad.sv - bus and split quad inverters with saturating output-transition monitor (INV_74X04_OUTPUT_REG_EN)
module inv_74x04_quad
  import inv74_pkg::*;
#(
  parameter int          CNT_W   = 16,
  parameter int unsigned RST_CNT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       a_bus,
  output logic [3:0]       y_bus,
  input  logic             a1,
  input  logic             a2,
  input  logic             a3,
  input  logic             a4,
  output logic             y1,
  output logic             y2,
  output logic             y3,
  output logic             y4,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             cnt_sat
);

  localparam logic [CNT_W+3:0] CNT_MAX = {4'b0000, {CNT_W{1'b1}}};

  quad_t a_split;
  quad_t y_split;

  assign a_split = {a4, a3, a2, a1};
  assign y1      = y_split[0];
  assign y2      = y_split[1];
  assign y3      = y_split[2];
  assign y4      = y_split[3];

  for (genvar g = 0; g < N_GATES; g++) begin : g_gates
    inv74_gate u_bus (
`ifdef INV_74X04_OUTPUT_REG_EN
      .clk (clk),
      .rst (rst),
`endif
      .a   (a_bus[g]),
      .y   (y_bus[g])
    );
    inv74_gate u_split (
`ifdef INV_74X04_OUTPUT_REG_EN
      .clk (clk),
      .rst (rst),
`endif
      .a   (a_split[g]),
      .y   (y_split[g])
    );
  end

  logic [7:0]       cur_y;
  logic [7:0]       prev_y;
  logic [7:0]       toggled;
  logic [CNT_W+3:0] sum;
  logic [CNT_W-1:0] cnt_next;

  assign cur_y = {y_split, y_bus};

  // A bit that is not a clean 0/1 on either side is never a transition
  always_comb begin
    toggled = '0;
    for (int i = 0; i < 8; i++) begin
      toggled[i] = ((prev_y[i] === 1'b0) && (cur_y[i] === 1'b1)) ||
                   ((prev_y[i] === 1'b1) && (cur_y[i] === 1'b0));
    end
  end

  always_comb begin
    sum      = {4'b0000, toggle_cnt} + {{CNT_W{1'b0}}, popcount8(toggled)};
    cnt_next = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_cnt <= CNT_W'(RST_CNT);
`ifdef INV_74X04_OUTPUT_REG_EN
      // Outputs are being forced high on this edge, so that is what they will hold next cycle
      prev_y     <= '1;
`else
      prev_y     <= cur_y;
`endif
    end else begin
      toggle_cnt <= cnt_next;
      prev_y     <= cur_y;
    end
  end

  assign cnt_sat = &toggle_cnt;

endmodule

// File: tb/tb_inv_74x04_quad.sv
// tb/tb_inv_74x04_quad.sv - scoreboard bench for inv_74x04_quad (default and INV_74X04_OUTPUT_REG_EN builds)
module tb_inv_74x04_quad;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  a_bus;
  logic        a1, a2, a3, a4;
  logic [3:0]  y_bus, y_bus_s;
  logic        y1, y2, y3, y4;
  logic        y1_s, y2_s, y3_s, y4_s;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;
  logic        sat16, sat4;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0] bus;
    logic [3:0] split;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  inv_74x04_quad #(.CNT_W(16), .RST_CNT(0)) dut (
    .clk (clk), .rst (rst), .a_bus (a_bus), .y_bus (y_bus),
    .a1 (a1), .a2 (a2), .a3 (a3), .a4 (a4),
    .y1 (y1), .y2 (y2), .y3 (y3), .y4 (y4),
    .toggle_cnt (cnt16), .cnt_sat (sat16)
  );

  inv_74x04_quad #(.CNT_W(4), .RST_CNT(0)) dut_small (
    .clk (clk), .rst (rst), .a_bus (a_bus), .y_bus (y_bus_s),
    .a1 (a1), .a2 (a2), .a3 (a3), .a4 (a4),
    .y1 (y1_s), .y2 (y2_s), .y3 (y3_s), .y4 (y4_s),
    .toggle_cnt (cnt4), .cnt_sat (sat4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive both sections, queue the expected inverse, then compare once the output is due
  task automatic apply(input string tag, input logic [3:0] bus, input logic [3:0] split);
    exp_t e;
    a_bus = bus;
    {a4, a3, a2, a1} = split;
    sb_q.push_back('{bus: ~bus, split: ~split});
`ifdef INV_74X04_OUTPUT_REG_EN
    @(posedge clk);
    #1;
`else
    #20;
`endif
    e = sb_q.pop_front();
    check({tag, "_bus"}, {28'd0, y_bus}, {28'd0, e.bus});
    check({tag, "_split"}, {28'd0, y4, y3, y2, y1}, {28'd0, e.split});
  endtask

  initial begin
    rst = 1'b1;
    a_bus = 4'b0000;
    {a4, a3, a2, a1} = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cnt16", {16'd0, cnt16}, 32'd0);
    check("rst_cnt4", {28'd0, cnt4}, 32'd0);
    check("rst_sat", {31'd0, sat4}, 32'd0);
    check("rst_y_bus", {28'd0, y_bus}, 32'hF);
    rst = 1'b0;

    apply("all_high", 4'b1111, 4'b1111);
    apply("all_low", 4'b0000, 4'b0000);
    apply("pat_1010", 4'b1010, 4'b0101);
    for (int i = 0; i < 4; i++) begin
      apply($sformatf("walk1_%0d", i), 4'b0001 << i, 4'b0001 << i);
    end
    check("sb_empty", sb_q.size(), 32'd0);

`ifdef INV_74X04_OUTPUT_REG_EN
    @(negedge clk);
    rst = 1'b1;
    a_bus = 4'b1111;
    {a4, a3, a2, a1} = 4'b1111;
    @(negedge clk);
    check("reg_rst_bus", {28'd0, y_bus}, 32'hF);
    check("reg_rst_split", {28'd0, y4, y3, y2, y1}, 32'hF);
    rst = 1'b0;
    a_bus = 4'b0000;
    @(negedge clk);
    a_bus = 4'b1111;
    #1;
    check("reg_not_before", {28'd0, y_bus}, 32'hF);
    @(negedge clk);
    check("reg_one_clk", {28'd0, y_bus}, 32'h0);
`else
    // Four bus outputs flip on each of three cycles
    @(negedge clk);
    rst = 1'b1;
    a_bus = 4'b0000;
    {a4, a3, a2, a1} = 4'b0000;
    @(negedge clk);
    check("mon_rst", {16'd0, cnt16}, 32'd0);
    rst = 1'b0;
    a_bus = 4'b1111;
    @(negedge clk);
    a_bus = 4'b0000;
    @(negedge clk);
    a_bus = 4'b1111;
    @(negedge clk);
    check("mon_cnt12", {16'd0, cnt16}, 32'd12);
    check("mon_sat0", {31'd0, sat16}, 32'd0);
    check("mon_small12", {28'd0, cnt4}, 32'd12);
    @(negedge clk);
    check("mon_stable", {16'd0, cnt16}, 32'd12);

    // All eight outputs flip each cycle; the 4-bit counter must clamp at 15
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      a_bus = ~a_bus;
      {a4, a3, a2, a1} = ~{a4, a3, a2, a1};
      @(negedge clk);
      check($sformatf("sat_cnt4_%0d", k), {28'd0, cnt4}, (8 * k > 15) ? 32'd15 : 32'(8 * k));
      check($sformatf("sat_flag_%0d", k), {31'd0, sat4}, (8 * k >= 15) ? 32'd1 : 32'd0);
      check($sformatf("sat_cnt16_%0d", k), {16'd0, cnt16}, 32'(8 * k));
    end
    rst = 1'b1;
    @(negedge clk);
    check("sat_rst_cnt", {28'd0, cnt4}, 32'd0);
    check("sat_rst_flag", {31'd0, sat4}, 32'd0);
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
